// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, stall outputs and single-port RAM bus
// shared between the memory arbiter and the blocks around it.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;

  logic          stall_f;
  logic          stall_m;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output stall_f, stall_m,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  stall_f, stall_m,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port synchronous RAM. Data wins
// contention until it has starved fetch for MAX_DSTREAK consecutive grants.
//
// Response tag (no multi-state FSM, the tag is the only control state):
//   tagValid tagOwnerD | meaning
//   0        x         | no response next cycle
//   1        0         | fetch response next cycle (F)
//   1        1         | data read data / write ack next cycle (D)
module mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

  logic          dGnt;
  logic          ifGnt;
  logic [3:0]    dStreak;
  logic          tagValid;
  logic          tagOwnerD;
  logic [AW-1:0] grantAddr;
  logic [DW-1:0] grantWdata;

  // Grants are masked while reset is held so the RAM never sees an access.
  always_comb begin
    dGnt  = reset & bus.d_req & ~(bus.if_req & (dStreak == MaxStreak));
    ifGnt = reset & bus.if_req & ~dGnt;
  end

  always_comb begin
    grantAddr  = dGnt ? bus.d_addr : bus.if_addr;
    grantWdata = bus.d_wdata;
  end

  assign bus.d_gnt     = dGnt;
  assign bus.if_gnt    = ifGnt;
  assign bus.stall_f   = bus.if_req & ~ifGnt;
  assign bus.stall_m   = bus.d_req & ~dGnt;

  assign bus.mem_en    = dGnt | ifGnt;
  assign bus.mem_we    = dGnt & bus.d_we;
  assign bus.mem_addr  = grantAddr;
  assign bus.mem_wdata = grantWdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dStreak <= 4'd0;
    end else if (!bus.if_req || ifGnt) begin
      dStreak <= 4'd0;
    end else if (dGnt && (dStreak != MaxStreak)) begin
      dStreak <= dStreak + 4'd1;
    end
  end

  // A fetch granted under flush is already dead, so it never becomes valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tagValid  <= 1'b0;
      tagOwnerD <= 1'b0;
    end else begin
      tagValid  <= dGnt | (ifGnt & ~bus.if_flush);
      tagOwnerD <= dGnt;
    end
  end

  assign bus.if_rvalid = tagValid & ~tagOwnerD & ~bus.if_flush;
  assign bus.d_rvalid  = tagValid & tagOwnerD;
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;

endmodule
